intr_arbiter: RTL

Collects interrupt requests from up to NDEV on-chip Unibus device emulations, such as the line clock, and arbitrates among them. It runs the bus-request / bus-grant / interrupt-vector transaction toward the PDP-11 on a single BR level. It returns a one-cycle grant with the serviced vector to the winning device. It sits between the device blocks' intreq/irvec/intgnt/igvec ports and the Unibus pin drivers.

---
 rtl/intr_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/intr_arbiter.sv
// intr_arbiter: collects level interrupt requests from on-chip Unibus device
// emulations and runs one BR/BG/SACK/BBSY/INTR transaction per winning device.
//
// Ports:
//   CLOCK, RESET          fabric clock, asynchronous active-high reset
//   intreqs, irvecs       per-device request level and 8-bit vector
//   intgnt, igvec         one-cycle grant pulse and the vector that was served
//   bg_in_h / bg_out_h    bus grant daisy chain in / out
//   bbsy_in_h, ssyn_in_h  bus busy and slave sync from other masters/CPU
//   sack_in_h             select acknowledge from others (monitored only)
//   init_in_h             Unibus INIT, synchronous abort of any transaction
//   br_out_h, sack_out_h, bbsy_out_h, intr_out_h, d_out_h  Unibus drivers
//   armraddr, armrdata    status readback (ID word / live status word)

module intr_arbiter #(
    parameter int NDEV = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [NDEV-1:0]   intreqs,
    input  logic [8*NDEV-1:0] irvecs,
    output logic              intgnt,
    output logic [7:0]        igvec,
    input  logic              bg_in_h,
    output logic              bg_out_h,
    input  logic              bbsy_in_h,
    input  logic              ssyn_in_h,
    input  logic              sack_in_h,
    input  logic              init_in_h,
    output logic              br_out_h,
    output logic              sack_out_h,
    output logic              bbsy_out_h,
    output logic              intr_out_h,
    output logic [15:0]       d_out_h,
    input  logic              armraddr,
    output logic [31:0]       armrdata
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] SACK   = 3'd2;
    localparam logic [2:0] MASTER = 3'd3;
    localparam logic [2:0] INTR   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [31:0] ID_WORD = 32'h4941_0003;

    logic [2:0]  state;
    logic [3:0]  sel;
    logic [7:0]  vec;
    logic [7:0]  timeouts;
    logic [15:0] cnt;
    logic        holdoff;

    logic [3:0]  pick;
    logic [7:0]  pick_vec;
    logic        any_req;
    logic        expire;
    logic [7:0]  req8;

    // Other masters' select acknowledge is not needed for a single BR
    // level; it is only kept on the port list for pin compatibility.
    logic unused_sack;
    assign unused_sack = sack_in_h;

    assign any_req = |intreqs;

    // Lowest index wins: scanning from the top lets lower indices overwrite.
    always_comb begin
        pick     = 4'd0;
        pick_vec = 8'h00;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (intreqs[i]) begin
                pick     = 4'(i);
                pick_vec = irvecs[8*i +: 8];
            end
        end
    end

    // The watchdog only runs while waiting on the other side of the bus.
    assign expire = (cnt == 16'hFFFF) && ((state == SACK) || (state == INTR));

    // A grant is swallowed only while we are requesting; anywhere else it
    // belongs to a device further down the chain.
    assign bg_out_h = bg_in_h & ~RESET & (state != REQ);

    always_comb begin
        req8 = 8'h00;
        for (int i = 0; i < NDEV && i < 8; i++) begin
            req8[i] = intreqs[i];
        end
    end

    always_comb begin
        if (armraddr) begin
            armrdata = {1'b0, state, sel, 8'h00, timeouts, req8};
        end else begin
            armrdata = ID_WORD;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            sel        <= 4'd0;
            vec        <= 8'h00;
            timeouts   <= 8'h00;
            cnt        <= 16'h0000;
            holdoff    <= 1'b0;
            br_out_h   <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            intr_out_h <= 1'b0;
            d_out_h    <= 16'h0000;
            intgnt     <= 1'b0;
            igvec      <= 8'h00;
        end else if (init_in_h) begin
            // Bus INIT abandons the transaction but keeps the abort history.
            state      <= IDLE;
            cnt        <= 16'h0000;
            holdoff    <= 1'b0;
            br_out_h   <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            intr_out_h <= 1'b0;
            d_out_h    <= 16'h0000;
            intgnt     <= 1'b0;
            igvec      <= 8'h00;
        end else if (expire) begin
            // Give up the bus; the device still requests and is re-arbitrated.
            state      <= IDLE;
            cnt        <= 16'h0000;
            br_out_h   <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            intr_out_h <= 1'b0;
            d_out_h    <= 16'h0000;
            intgnt     <= 1'b0;
            igvec      <= 8'h00;
            if (timeouts != 8'hFF) begin
                timeouts <= timeouts + 8'd1;
            end
        end else begin
            intgnt <= 1'b0;
            igvec  <= 8'h00;
            unique case (state)
                IDLE: begin
                    // Skip one look after a grant: the served device only
                    // drops its level on the cycle after intgnt.
                    if (holdoff) begin
                        holdoff <= 1'b0;
                    end else if (any_req) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bg_in_h && any_req) begin
                        sel        <= pick;
                        vec        <= pick_vec;
                        br_out_h   <= 1'b0;
                        sack_out_h <= 1'b1;
                        cnt        <= 16'h0000;
                        state      <= SACK;
                    end else if (!any_req) begin
                        br_out_h <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        br_out_h <= 1'b1;
                    end
                end
                SACK: begin
                    if (!bg_in_h && !bbsy_in_h && !ssyn_in_h) begin
                        sack_out_h <= 1'b0;
                        bbsy_out_h <= 1'b1;
                        d_out_h    <= {8'h00, vec};
                        state      <= MASTER;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                MASTER: begin
                    intr_out_h <= 1'b1;
                    cnt        <= 16'h0000;
                    state      <= INTR;
                end
                INTR: begin
                    if (ssyn_in_h) begin
                        intr_out_h <= 1'b0;
                        bbsy_out_h <= 1'b0;
                        d_out_h    <= 16'h0000;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    intgnt  <= 1'b1;
                    igvec   <= vec;
                    holdoff <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
